// File: rtl/bram_stream_reader.sv
// Streams a contiguous run of BRAM words out over a valid/ready interface via a 4-entry FIFO.
// Optional feature: define BRAM_STREAM_READER_TLAST_EN to drive o_tlast on the final beat.
module bram_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_tvalid,
    output logic [DATA_WIDTH-1:0] o_tdata,
    input  logic                  i_tready,
    output logic                  o_tlast,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  issued_q, issued_d;
    logic                  rdvalid_q;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] fifo_q [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            count_q;

    logic                  push, pop, can_issue, last_head;
    logic [2:0]            occupancy;

    // issued_q: address on the BRAM port this cycle; rdvalid_q: its data on i_rd_data now
    assign push      = rdvalid_q;
    assign pop       = o_tvalid && i_tready;
    assign occupancy = count_q + {2'b00, issued_q} + {2'b00, rdvalid_q};
    assign can_issue = (state_q == RUN) && (occupancy < 3'd4);
    assign last_head = (state_q == DRAIN) && (count_q == 3'd1) && !issued_q && !rdvalid_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            rd_addr_q <= '0;
            issued_q  <= 1'b0;
            rdvalid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            rd_addr_q <= rd_addr_d;
            issued_q  <= issued_d;
            rdvalid_q <= issued_q;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        rd_addr_d = rd_addr_q;
        issued_d  = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        state_d = RUN;
                        addr_d  = i_base_addr;
                        rem_d   = i_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (can_issue) begin
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    rem_d     = rem_q - LEN_WIDTH'(1);
                    issued_d  = 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && last_head) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue throttling guarantees a push never meets a full FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= i_rd_data;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_rd_addr = rd_addr_q;
    assign o_tvalid  = (count_q != 3'd0);
    assign o_tdata   = fifo_q[rd_ptr_q];
    assign o_busy    = (state_q != IDLE);
    assign o_done    = done_q;

`ifdef BRAM_STREAM_READER_TLAST_EN
    assign o_tlast = o_tvalid && last_head;
`else
    assign o_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed self-checking bench for bram_stream_reader with a registered-read BRAM model (mem[k]=k).
// Expected o_tlast follows BRAM_STREAM_READER_TLAST_EN as seen by this bench's build.
module tb_bram_stream_reader;

    logic       clk;
    logic       rstN;
    logic       start;
    logic [7:0] baseAddr;
    logic [8:0] len;
    logic [7:0] rdAddr;
    logic [7:0] rdData;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tready;
    logic       tlast;
    logic       busy;
    logic       done;

    logic [7:0] bram [256];

    int testsRun = 0;
    int failCount = 0;
    int cyc = 0;
    int startCyc = 0;
    int doneCnt = 0;
    int doneCyc = 0;
    int busyAtDone = 0;
    int sawValid = 0;
    int readyMode = 0;
    int readyIdx = 0;
    int prevStall = 0;
    int prevData = 0;
    int beatData [$];
    int beatCyc [$];
    int beatLast [$];

`ifdef BRAM_STREAM_READER_TLAST_EN
    localparam int TLAST_EN = 1;
`else
    localparam int TLAST_EN = 0;
`endif

    bram_stream_reader dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (start),
        .i_base_addr (baseAddr),
        .i_len       (len),
        .o_rd_addr   (rdAddr),
        .i_rd_data   (rdData),
        .o_tvalid    (tvalid),
        .o_tdata     (tdata),
        .i_tready    (tready),
        .o_tlast     (tlast),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rdData <= bram[rdAddr];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic monitor();
        if (prevStall != 0) begin
            checkOutput("stall_data_hold", int'(tdata), prevData);
            checkOutput("stall_valid_hold", int'(tvalid), 1);
        end
        prevStall = (tvalid && !tready) ? 1 : 0;
        prevData  = int'(tdata);
        if (tvalid) sawValid = 1;
        if (tvalid && tready) begin
            beatData.push_back(int'(tdata));
            beatCyc.push_back(cyc);
            beatLast.push_back(int'(tlast));
        end
        if (done) begin
            doneCnt++;
            doneCyc    = cyc;
            busyAtDone = int'(busy);
        end
    endtask

    task automatic driveReady();
        if (readyMode == 0) begin
            tready = 1'b1;
        end else begin
            tready = ((readyIdx % 3) == 0);
            readyIdx++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        driveReady();
    endtask

    task automatic clearRecord();
        beatData.delete();
        beatCyc.delete();
        beatLast.delete();
        doneCnt  = 0;
        sawValid = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic [8:0] n);
        readyIdx = 0;
        driveReady();
        start    = 1'b1;
        baseAddr = b;
        len      = n;
        tick();
        start    = 1'b0;
        startCyc = cyc;
    endtask

    task automatic waitDone(input int maxCycles);
        int n = 0;
        int d0 = doneCnt;
        while (doneCnt == d0 && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("done_seen", (doneCnt != d0) ? 1 : 0, 1);
    endtask

    task automatic checkBeats(input int b, input int n, input int checkTiming);
        checkOutput("beat_count", beatData.size(), n);
        for (int i = 0; i < beatData.size() && i < n; i++) begin
            checkOutput($sformatf("beat_data[%0d]", i), beatData[i], (b + i) & 8'hFF);
            if (checkTiming != 0)
                checkOutput($sformatf("beat_cycle[%0d]", i), beatCyc[i] - startCyc, 3 + i);
            checkOutput($sformatf("beat_tlast[%0d]", i), beatLast[i],
                        (TLAST_EN != 0 && i == n - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int d0;
        for (int k = 0; k < 256; k++) bram[k] = k[7:0];
        rstN = 1'b0; start = 1'b0; baseAddr = '0; len = '0; tready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rd_addr", int'(rdAddr), 0);
        checkOutput("reset_tvalid", int'(tvalid), 0);
        checkOutput("reset_tdata", int'(tdata), 0);
        checkOutput("reset_tlast", int'(tlast), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        @(posedge clk); #1;
        rstN = 1'b1;
        tick(); tick();

        $display("[TB] basic transfer base=0x10 len=4");
        clearRecord();
        applyStimulus(8'h10, 9'd4);
        checkOutput("busy_after_start", int'(busy), 1);
        waitDone(50);
        checkBeats(8'h10, 4, 1);
        checkOutput("done_cycle", doneCyc - startCyc, 7);
        checkOutput("busy_at_done", busyAtDone, 0);
        repeat (4) tick();
        checkOutput("done_count", doneCnt, 1);

        $display("[TB] address wrap base=0xFE len=4");
        clearRecord();
        applyStimulus(8'hFE, 9'd4);
        waitDone(50);
        checkBeats(8'hFE, 4, 1);
        checkOutput("wrap_done_cycle", doneCyc - startCyc, 7);

        $display("[TB] backpressure len=6");
        clearRecord();
        readyMode = 1;
        applyStimulus(8'h30, 9'd6);
        waitDone(200);
        readyMode = 0;
        driveReady();
        repeat (3) tick();
        checkBeats(8'h30, 6, 0);
        checkOutput("stall_done_count", doneCnt, 1);

        $display("[TB] zero length start");
        clearRecord();
        applyStimulus(8'h00, 9'd0);
        checkOutput("len0_done", int'(done), 1);
        checkOutput("len0_busy", int'(busy), 0);
        repeat (5) tick();
        checkOutput("len0_done_count", doneCnt, 1);
        checkOutput("len0_done_cycle", doneCyc - startCyc, 0);
        checkOutput("len0_no_valid", sawValid, 0);

        $display("[TB] start ignored while busy");
        clearRecord();
        applyStimulus(8'h40, 9'd8);
        tick();
        start = 1'b1; baseAddr = 8'h80; len = 9'd3;
        tick();
        start = 1'b0;
        waitDone(100);
        repeat (6) tick();
        checkBeats(8'h40, 8, 1);
        checkOutput("ignored_done_count", doneCnt, 1);

        $display("[TB] reset mid-transfer");
        clearRecord();
        applyStimulus(8'h50, 9'd8);
        n = 0;
        while (beatData.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("pre_reset_beats", beatData.size(), 3);
        rstN = 1'b0;
        #1;
        checkOutput("mid_reset_tvalid", int'(tvalid), 0);
        checkOutput("mid_reset_tdata", int'(tdata), 0);
        checkOutput("mid_reset_tlast", int'(tlast), 0);
        checkOutput("mid_reset_busy", int'(busy), 0);
        checkOutput("mid_reset_done", int'(done), 0);
        checkOutput("mid_reset_rd_addr", int'(rdAddr), 0);
        @(posedge clk); #1;
        rstN = 1'b1;
        prevStall = 0;
        d0 = doneCnt;
        repeat (6) tick();
        checkOutput("no_done_after_reset", doneCnt - d0, 0);
        checkOutput("no_beats_after_reset", beatData.size(), 3);

        clearRecord();
        applyStimulus(8'h20, 9'd2);
        waitDone(50);
        repeat (3) tick();
        checkBeats(8'h20, 2, 1);
        checkOutput("restart_done_count", doneCnt, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
